// File: rtl/regfile_dump_reader_if.sv
// Dump stream channel of regfile_dump_reader: one register per beat, valid/ready handshake.
interface regfile_dump_reader_if #(
  parameter int DATA_W = 64,
  parameter int IDX_W  = 6
) ();
  logic              valid;
  logic              ready;
  logic [IDX_W-1:0]  idx;
  logic [DATA_W-1:0] data;
  logic              last;

  modport master (output valid, idx, data, last, input ready);
  modport slave  (input valid, idx, data, last, output ready);
endinterface

// File: rtl/regfile_dump_reader.sv
// Captures an atomic snapshot of the register file tap and streams it one register per beat.
// Define REGDUMP_CSUM_EN to append an XOR checksum beat after the registers.
module regfile_dump_reader #(
  parameter int DATA_W = 64,
  parameter int NREG   = 32,
  parameter int IDX_W  = 6
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NREG-1:0][DATA_W-1:0]  regs_i,
  input  logic                         trig_i,
  output logic                         busy_o,
  regfile_dump_reader_if.master        dump,
  output logic                         done_o
);

  localparam int SNAP_AW = $clog2(NREG);
`ifdef REGDUMP_CSUM_EN
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NREG);
`else
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NREG - 1);
`endif
  localparam logic [IDX_W-1:0] IDX_ONE = IDX_W'(1);

  typedef enum logic {IDLE, STREAM} state_t;

  state_t            state, state_nxt;
  logic [IDX_W-1:0]  idx_q;
  logic              done_q;
  logic [DATA_W-1:0] snap [NREG];
  logic [DATA_W-1:0] beat_data;
  logic              accept, last_beat, beat_fire;

  assign accept    = (state == IDLE) && trig_i;
  assign last_beat = (idx_q == LAST_IDX);
  assign beat_fire = (state == STREAM) && dump.ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (trig_i) state_nxt = STREAM;
      STREAM:  if (dump.ready && last_beat) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx_q  <= '0;
      done_q <= 1'b0;
    end else begin
      done_q <= beat_fire && last_beat;
      if (accept)         idx_q <= '0;
      else if (beat_fire) idx_q <= last_beat ? '0 : idx_q + IDX_ONE;
    end
  end

  // NOTE: the snapshot array has no reset; outputs are gated by state, so stale contents never leak.
  always_ff @(posedge clk) begin
    if (accept) begin
      for (int k = 0; k < NREG; k++) snap[k] <= regs_i[k];
    end
  end

`ifdef REGDUMP_CSUM_EN
  logic [DATA_W-1:0] csum_q, csum_nxt;

  // x0 is excluded from the checksum since its beat reads as zero.
  // NOTE: in always_comb a default comes first so no path leaves the signal unassigned (no latch).
  always_comb begin
    csum_nxt = '0;
    for (int k = 1; k < NREG; k++) csum_nxt = csum_nxt ^ regs_i[k];
  end

  always_ff @(posedge clk) begin
    if (accept) csum_q <= csum_nxt;
  end
`endif

  // x0 is architecturally hardwired to zero whatever the tap shows.
  always_comb begin
    beat_data = (idx_q == '0) ? '0 : snap[idx_q[SNAP_AW-1:0]];
`ifdef REGDUMP_CSUM_EN
    if (idx_q == LAST_IDX) beat_data = csum_q;
`endif
  end

  always_comb begin
    busy_o     = 1'b0;
    dump.valid = 1'b0;
    dump.idx   = '0;
    dump.data  = '0;
    dump.last  = 1'b0;
    if (state == STREAM) begin
      busy_o     = 1'b1;
      dump.valid = 1'b1;
      dump.idx   = idx_q;
      dump.data  = beat_data;
      dump.last  = last_beat;
    end
  end

  assign done_o = done_q;

endmodule

// File: tb/tb_regfile_dump_reader.sv
// Randomized bench for regfile_dump_reader against a queue-based model of the expected beat stream.
module tb_regfile_dump_reader;
  localparam int DATA_W = 64;
  localparam int NREG   = 32;
  localparam int IDX_W  = 6;
`ifdef REGDUMP_CSUM_EN
  localparam int NBEAT = NREG + 1;
`else
  localparam int NBEAT = NREG;
`endif

  logic                        clk = 1'b0;
  logic                        rst;
  logic [NREG-1:0][DATA_W-1:0] regs;
  logic                        trig;
  logic                        busy, done;
  logic [DATA_W-1:0]           exp_q [$];
  int                          checks = 0;
  int                          errors = 0;

  regfile_dump_reader_if #(.DATA_W(DATA_W), .IDX_W(IDX_W)) dump_if ();

  regfile_dump_reader #(.DATA_W(DATA_W), .NREG(NREG), .IDX_W(IDX_W)) dut (
    .clk    (clk),
    .rst    (rst),
    .regs_i (regs),
    .trig_i (trig),
    .busy_o (busy),
    .dump   (dump_if),
    .done_o (done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic check_idle(input string tag);
    check({tag, " valid"}, 64'(dump_if.valid), 64'd0);
    check({tag, " busy"},  64'(busy),          64'd0);
    check({tag, " done"},  64'(done),          64'd0);
    check({tag, " last"},  64'(dump_if.last),  64'd0);
    check({tag, " idx"},   64'(dump_if.idx),   64'd0);
    check({tag, " data"},  dump_if.data,       64'd0);
  endtask

  // Expected stream: x0 reads as zero, then registers in order, then optional XOR of all beats.
  task automatic build_expected();
    logic [DATA_W-1:0] csum;
    csum  = '0;
    exp_q = {};
    for (int k = 0; k < NREG; k++) begin
      exp_q.push_back(k == 0 ? '0 : regs[k]);
      csum ^= exp_q[k];
    end
    if (NBEAT > NREG) exp_q.push_back(csum);
  endtask

  task automatic set_pattern();
    for (int k = 0; k < NREG; k++) regs[k] = 64'(k) * 64'h0101_0101_0101_0101;
    regs[0] = 64'hDEAD;
  endtask

  task automatic set_random();
    for (int k = 0; k < NREG; k++) regs[k] = {$urandom, $urandom};
  endtask

  // Entered and left on a falling edge. ready_mode: 0 always, 1 pattern 1,0,0,1, 2 random.
  task automatic do_dump(input int ready_mode, input int mid_trig_beat,
                         input int reset_beat, input int chg_reg);
    int   beat, cyc;
    bit   trig_sent, r;
    bit   pat [4];
    pat = '{1'b1, 1'b0, 1'b0, 1'b1};
    build_expected();
    trig = 1'b1;
    @(negedge clk);
    trig = 1'b0;
    if (chg_reg >= 0) regs[chg_reg] = 64'hFFFF;
    beat = 0;
    cyc  = 0;
    trig_sent = 1'b0;
    while (beat < NBEAT) begin
      if (cyc > 8 * NBEAT) begin
        check("beat timeout", 64'(beat), 64'(NBEAT));
        break;
      end
      check("valid", 64'(dump_if.valid), 64'd1);
      check("busy",  64'(busy),          64'd1);
      check("idx",   64'(dump_if.idx),   64'(beat));
      check("data",  dump_if.data,       exp_q[beat]);
      check("last",  64'(dump_if.last),  64'(beat == NBEAT - 1));
      check("done during stream", 64'(done), 64'd0);
      if (beat == reset_beat) begin
        rst = 1'b1;
        #1;
        check_idle("async reset");
        dump_if.ready = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        return;
      end
      trig = (beat == mid_trig_beat) && !trig_sent;
      if (trig) trig_sent = 1'b1;
      case (ready_mode)
        0:       r = 1'b1;
        1:       r = pat[cyc % 4];
        default: r = 1'($urandom_range(0, 1));
      endcase
      dump_if.ready = r;
      if (r) beat++;
      cyc++;
      @(negedge clk);
    end
    trig = 1'b0;
    check("done pulse", 64'(done),          64'd1);
    check("post valid", 64'(dump_if.valid), 64'd0);
    check("post busy",  64'(busy),          64'd0);
    check("post last",  64'(dump_if.last),  64'd0);
  endtask

  initial begin
    rst           = 1'b1;
    trig          = 1'b0;
    dump_if.ready = 1'b0;
    set_random();
    #2;
    check_idle("reset");
    @(negedge clk);
    @(negedge clk);
    check_idle("reset held");
    rst = 1'b0;
    @(negedge clk);
    check_idle("idle");

    // Full-rate dump, then a stalled dump triggered in the done cycle.
    set_pattern();
    do_dump(0, -1, -1, -1);
    do_dump(1, -1, -1, -1);
    @(negedge clk);
    check_idle("after stalled dump");

    // Post-trigger tap change must not leak; trigger while busy is dropped.
    set_random();
    do_dump(2, 12, -1, 5);
    @(negedge clk);
    check_idle("no queued trig");
    @(negedge clk);
    check_idle("single done");

    // Reset mid-stream aborts without done; the next dump restarts from idx 0.
    set_pattern();
    do_dump(0, -1, 10, -1);
    check_idle("after abort");
    @(negedge clk);
    check_idle("no done after abort");
    do_dump(0, -1, -1, -1);

    // Checksum-friendly pattern.
    for (int k = 0; k < NREG; k++) regs[k] = 64'(k);
    do_dump(0, -1, -1, -1);

    // Random back-to-back dumps with random backpressure.
    for (int n = 0; n < 4; n++) begin
      set_random();
      do_dump(2, -1, -1, -1);
    end
    @(negedge clk);
    check_idle("final idle");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
